// File: rtl/alu_result_tx.sv
// alu_result_tx: buffers ALU result bytes plus carry/overflow in a small
// FIFO and sends each entry as a 13-bit framed word on one serial pin.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       ALU result below is valid this cycle
//   in_ready       FIFO can accept an entry (not full)
//   in_result      8-bit ALU result
//   in_carry       ALU carry out
//   in_overflow    ALU overflow
//   clr_lost       clear the sticky lost flag
//   tx             serial line, idles high
//   busy           a frame is in progress
//   fifo_count     occupied FIFO entries
//   lost           sticky: a result was offered while the FIFO was full
//
// Frame: start(0), result[0..7], carry, overflow, even parity, stop(1).

module alu_result_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [7:0]                    in_result,
   input  logic                          in_carry,
   input  logic                          in_overflow,
   input  logic                          clr_lost,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          lost
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PAYLOAD,
      S_PARITY,
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          r_lost;

   // Transmitter state
   state_t        r_state;
   logic [BW-1:0] r_baud;
   logic [3:0]    r_bitcnt;
   logic [9:0]    r_shift;
   logic          r_parity;
   logic          r_tx;
   logic          r_busy;

   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic          w_baud_end;
   logic [9:0]    w_head;

   assign w_full     = (r_count == DEPTH_C);
   assign w_push     = in_valid && !w_full;
   // The transmitter only takes a new entry while idle.
   assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
   assign w_baud_end = (r_baud == BAUD_LAST);
   assign w_head     = r_mem[r_rptr];

   assign in_ready   = !w_full;
   assign fifo_count = r_count;
   assign lost       = r_lost;
   assign tx         = r_tx;
   assign busy       = r_busy;

   // Storage is not reset; occupancy is tracked by r_count alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {in_overflow, in_carry, in_result};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Set has priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lost <= 1'b0;
      end else if (in_valid && w_full) begin
         r_lost <= 1'b1;
      end else if (clr_lost) begin
         r_lost <= 1'b0;
      end
   end

   // tx/busy are registered with the state so the line never sees
   // a combinational path from the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bitcnt <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_baud   <= '0;
               r_bitcnt <= '0;
               if (w_pop) begin
                  r_shift  <= w_head;
                  r_parity <= ^w_head;
                  r_tx     <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_START;
               end else begin
                  r_tx     <= 1'b1;
                  r_busy   <= 1'b0;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_PAYLOAD;
               end else begin
                  r_baud  <= r_baud + BW'(1);
               end
            end
            S_PAYLOAD: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bitcnt == 4'd9) begin
                     r_tx    <= r_parity;
                     r_state <= S_PARITY;
                  end else begin
                     // Next bit is the one about to shift into bit 0.
                     r_bitcnt <= r_bitcnt + 4'd1;
                     r_shift  <= {1'b0, r_shift[9:1]};
                     r_tx     <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_PARITY: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud  <= r_baud + BW'(1);
               end
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_baud  <= r_baud + BW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
